// File: rtl/detokenizer.sv
// Token-to-character detokenizer: looks up a vocab entry per token and streams its
// non-padding bytes most-significant first over a valid/ready character interface.
module detokenizer #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned WORD_LENGTH = 3,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned VOCAB_SIZE  = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              token_valid,
  output logic                              token_ready,
  input  logic [ADDR_WIDTH-1:0]             token_id,
  output logic                              vocab_rd_en,
  output logic [ADDR_WIDTH-1:0]             vocab_addr,
  input  logic [WORD_LENGTH*DATA_WIDTH-1:0] vocab_data,
  output logic                              char_valid,
  input  logic                              char_ready,
  output logic [DATA_WIDTH-1:0]             char_data,
  output logic                              char_last,
  output logic                              err_invalid,
  output logic                              busy
);

  localparam int unsigned ENTRY_W = WORD_LENGTH * DATA_WIDTH;
  localparam int unsigned IDX_W   = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, EMIT} state_t;

  state_t                  r_state;
  logic [ENTRY_W-1:0]      r_entry;
  logic [WORD_LENGTH-1:0]  r_mask;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_token_ready;
  logic                    r_vocab_rd_en;
  logic [ADDR_WIDTH-1:0]   r_vocab_addr;
  logic                    r_char_valid;
  logic [DATA_WIDTH-1:0]   r_char_data;
  logic                    r_char_last;
  logic                    r_err;

  logic [WORD_LENGTH-1:0]  w_load_mask;
  logic [WORD_LENGTH-1:0]  w_rem;
  logic [WORD_LENGTH-1:0]  w_src_mask;
  logic [ENTRY_W-1:0]      w_src_data;
  logic [IDX_W-1:0]        w_nxt_idx;
  logic [DATA_WIDTH-1:0]   w_nxt_char;
  logic                    w_nxt_last;
  logic                    w_accept;
  logic                    w_tok_ok;

  assign w_accept = token_valid && r_token_ready;
  assign w_tok_ok = 32'(token_id) < VOCAB_SIZE;

  // Non-zero byte mask of the incoming entry; zero bytes are padding.
  always_comb begin
    w_load_mask = '0;
    for (int unsigned i = 0; i < WORD_LENGTH; i++) begin
      w_load_mask[i] = |vocab_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Remaining bytes after the one currently presented.
  assign w_rem      = r_mask & ~(WORD_LENGTH'(1) << r_idx);
  assign w_src_mask = (r_state == LOAD) ? w_load_mask : w_rem;
  assign w_src_data = (r_state == LOAD) ? vocab_data : r_entry;

  // Pick the highest remaining byte; ascending scan leaves the top index.
  always_comb begin
    w_nxt_idx  = '0;
    w_nxt_char = '0;
    for (int unsigned i = 0; i < WORD_LENGTH; i++) begin
      if (w_src_mask[i]) begin
        w_nxt_idx  = IDX_W'(i);
        w_nxt_char = w_src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_nxt_last = ((w_src_mask & ~(WORD_LENGTH'(1) << w_nxt_idx)) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_entry       <= '0;
      r_mask        <= '0;
      r_idx         <= '0;
      r_token_ready <= 1'b0;
      r_vocab_rd_en <= 1'b0;
      r_vocab_addr  <= '0;
      r_char_valid  <= 1'b0;
      r_char_data   <= '0;
      r_char_last   <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_err         <= 1'b0;
      r_vocab_rd_en <= 1'b0;
      case (r_state)
        IDLE: begin
          r_token_ready <= 1'b1;
          if (w_accept) begin
            if (w_tok_ok) begin
              r_state       <= FETCH;
              r_vocab_addr  <= token_id;
              r_vocab_rd_en <= 1'b1;
              r_token_ready <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        FETCH: r_state <= LOAD;
        LOAD: begin
          r_entry <= vocab_data;
          r_mask  <= w_load_mask;
          if (w_load_mask == '0) begin
            r_err         <= 1'b1;
            r_state       <= IDLE;
            r_token_ready <= 1'b1;
          end else begin
            r_state      <= EMIT;
            r_idx        <= w_nxt_idx;
            r_char_valid <= 1'b1;
            r_char_data  <= w_nxt_char;
            r_char_last  <= w_nxt_last;
          end
        end
        EMIT: begin
          if (char_ready) begin
            if (w_rem == '0) begin
              r_state       <= IDLE;
              r_char_valid  <= 1'b0;
              r_char_data   <= '0;
              r_char_last   <= 1'b0;
              r_token_ready <= 1'b1;
            end else begin
              r_mask      <= w_rem;
              r_idx       <= w_nxt_idx;
              r_char_data <= w_nxt_char;
              r_char_last <= w_nxt_last;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign token_ready = r_token_ready;
  assign vocab_rd_en = r_vocab_rd_en;
  assign vocab_addr  = r_vocab_addr;
  assign char_valid  = r_char_valid;
  assign char_data   = r_char_data;
  assign char_last   = r_char_last;
  assign err_invalid = r_err;
  assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_detokenizer.sv
// Bench for detokenizer: directed tokens against a vocab memory model, with a
// queue-based reference of expected characters/errors checked every cycle.
module tb_detokenizer;

  localparam int unsigned AW = 4;
  localparam int unsigned WL = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned VS = 12;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             token_valid;
  logic             token_ready;
  logic [AW-1:0]    token_id;
  logic             vocab_rd_en;
  logic [AW-1:0]    vocab_addr;
  logic [WL*DW-1:0] vocab_data = '0;
  logic             char_valid;
  logic             char_ready;
  logic [DW-1:0]    char_data;
  logic             char_last;
  logic             err_invalid;
  logic             busy;

  logic             man_ready;
  logic             rand_ready;
  logic             rnd_bit = 1'b1;

  logic [WL*DW-1:0] vocab [16];

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  exp_t exp_q[$];
  int   exp_err = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  detokenizer #(
    .ADDR_WIDTH(AW), .WORD_LENGTH(WL), .DATA_WIDTH(DW), .VOCAB_SIZE(VS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .token_valid(token_valid), .token_ready(token_ready), .token_id(token_id),
    .vocab_rd_en(vocab_rd_en), .vocab_addr(vocab_addr), .vocab_data(vocab_data),
    .char_valid(char_valid), .char_ready(char_ready), .char_data(char_data),
    .char_last(char_last), .err_invalid(err_invalid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read vocab memory; garbage when no read so stale capture shows up.
  always @(posedge clk) vocab_data <= vocab_rd_en ? vocab[vocab_addr] : 24'hA5A5A5;

  always begin
    @(posedge clk);
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  assign char_ready = rand_ready ? rnd_bit : man_ready;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected output of one token: error, or its non-zero bytes top byte first.
  function automatic void model_push(input int id);
    logic [DW-1:0] bytes[$];
    logic [WL*DW-1:0] e;
    exp_t it;
    if (id >= int'(VS)) begin
      exp_err++;
      return;
    end
    e = vocab[id];
    for (int b = int'(WL) - 1; b >= 0; b--) begin
      if (e[b*DW +: DW] != '0) bytes.push_back(e[b*DW +: DW]);
    end
    if (bytes.size() == 0) begin
      exp_err++;
      return;
    end
    for (int i = 0; i < bytes.size(); i++) begin
      it.d = bytes[i];
      it.l = (i == bytes.size() - 1);
      exp_q.push_back(it);
    end
  endfunction

  // Reference comparison, sampled mid-cycle once inputs are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_err = 0;
    end else begin
      chk("ready_vs_busy", 32'(token_ready), 32'(!busy));
      if (vocab_rd_en) chk("rd_addr_range", 32'(32'(vocab_addr) < VS), 1);
      if (err_invalid) begin
        chk("err_expected", 32'(exp_err > 0), 1);
        if (exp_err > 0) exp_err--;
      end
      if (char_valid) begin
        chk("char_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("model_char_data", 32'(char_data), 32'(exp_q[0].d));
          chk("model_char_last", 32'(char_last), 32'(exp_q[0].l));
          if (char_ready) void'(exp_q.pop_front());
        end
      end
      if (token_valid && token_ready) model_push(int'(token_id));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a token from #1 after an edge; returns #1 after the accept edge.
  task automatic send(input logic [AW-1:0] id);
    int n = 0;
    while (!token_ready && n < 50) begin
      step();
      n++;
    end
    chk("send_ready", 32'(token_ready), 1);
    token_valid = 1'b1;
    token_id    = id;
    step();
    token_valid = 1'b0;
  endtask

  // Full decode of id 2 ("Hel") with char_ready held high, starting just after accept.
  task automatic hel_check();
    chk("fetch_rd_en", 32'(vocab_rd_en), 1);
    chk("fetch_addr", 32'(vocab_addr), 2);
    chk("fetch_ready", 32'(token_ready), 0);
    step();
    chk("load_rd_en", 32'(vocab_rd_en), 0);
    chk("load_addr_hold", 32'(vocab_addr), 2);
    chk("load_no_char", 32'(char_valid), 0);
    step();
    chk("c0_valid", 32'(char_valid), 1);
    chk("c0_data", 32'(char_data), 32'h48);
    chk("c0_last", 32'(char_last), 0);
    step();
    chk("c1_data", 32'(char_data), 32'h65);
    chk("c1_last", 32'(char_last), 0);
    step();
    chk("c2_data", 32'(char_data), 32'h6C);
    chk("c2_last", 32'(char_last), 1);
    step();
    chk("done_valid", 32'(char_valid), 0);
    chk("done_ready", 32'(token_ready), 1);
    chk("done_busy", 32'(busy), 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_char_valid"}, 32'(char_valid), 0);
    chk({tag, "_char_last"}, 32'(char_last), 0);
    chk({tag, "_char_data"}, 32'(char_data), 0);
    chk({tag, "_err"}, 32'(err_invalid), 0);
    chk({tag, "_rd_en"}, 32'(vocab_rd_en), 0);
    chk({tag, "_addr"}, 32'(vocab_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ready"}, 32'(token_ready), 0);
  endtask

  initial begin
    logic [AW-1:0] toks[12];
    int n;
    rst_n       = 1'b0;
    token_valid = 1'b0;
    token_id    = '0;
    man_ready   = 1'b1;
    rand_ready  = 1'b0;
    vocab[0]  = 24'h000000;  vocab[1]  = 24'h00007A;  vocab[2]  = 24'h48656C;
    vocab[3]  = 24'h003100;  vocab[4]  = 24'h616200;  vocab[5]  = 24'h410042;
    vocab[6]  = 24'h000102;  vocab[7]  = 24'hFF0000;  vocab[8]  = 24'h202122;
    vocab[9]  = 24'h7F0080;  vocab[10] = 24'h000000;  vocab[11] = 24'h5A5A5A;
    vocab[12] = 24'h585858;  vocab[13] = 24'h595959;  vocab[14] = 24'h5A5A5A;
    vocab[15] = 24'h4E4E4E;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_ready", 32'(token_ready), 1);
    chk("post_rst_busy", 32'(busy), 0);

    send(4'd2);
    hel_check();

    // Back-pressure while the middle character is presented.
    send(4'd2);
    step();
    step();
    chk("bp_c0", 32'(char_data), 32'h48);
    step();
    chk("bp_c1", 32'(char_data), 32'h65);
    man_ready = 1'b0;
    step();
    chk("bp_hold1_data", 32'(char_data), 32'h65);
    chk("bp_hold1_valid", 32'(char_valid), 1);
    chk("bp_hold1_last", 32'(char_last), 0);
    step();
    chk("bp_hold2_data", 32'(char_data), 32'h65);
    chk("bp_hold2_last", 32'(char_last), 0);
    man_ready = 1'b1;
    step();
    chk("bp_c2_data", 32'(char_data), 32'h6C);
    chk("bp_c2_last", 32'(char_last), 1);
    step();
    chk("bp_done", 32'(char_valid), 0);

    // Interior padding is skipped.
    send(4'd5);
    step();
    step();
    chk("pad_c0_data", 32'(char_data), 32'h41);
    chk("pad_c0_last", 32'(char_last), 0);
    step();
    chk("pad_c1_data", 32'(char_data), 32'h42);
    chk("pad_c1_last", 32'(char_last), 1);
    step();
    chk("pad_done", 32'(char_valid), 0);

    // Null entry: one error pulse, nothing emitted.
    send(4'd0);
    step();
    step();
    chk("null_err", 32'(err_invalid), 1);
    chk("null_no_char", 32'(char_valid), 0);
    step();
    chk("null_err_clr", 32'(err_invalid), 0);
    chk("null_ready", 32'(token_ready), 1);
    chk("null_busy", 32'(busy), 0);

    // Out-of-range id rejected without a memory read.
    send(4'd15);
    chk("oor_err", 32'(err_invalid), 1);
    chk("oor_rd_en", 32'(vocab_rd_en), 0);
    chk("oor_busy", 32'(busy), 0);
    step();
    chk("oor_err_clr", 32'(err_invalid), 0);
    chk("oor_rd_en2", 32'(vocab_rd_en), 0);
    chk("oor_ready", 32'(token_ready), 1);

    // Reset in the middle of emission discards the token.
    send(4'd2);
    step();
    step();
    step();
    chk("mid_c1", 32'(char_data), 32'h65);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outs("mid_rst");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    step();
    chk("mid_post_ready", 32'(token_ready), 1);
    chk("mid_post_valid", 32'(char_valid), 0);
    send(4'd2);
    hel_check();

    // Mixed stream under random back-pressure, checked by the reference queue.
    toks = '{4'd1, 4'd3, 4'd4, 4'd6, 4'd5, 4'd15, 4'd0, 4'd7, 4'd11, 4'd12, 4'd9, 4'd8};
    rand_ready = 1'b1;
    foreach (toks[i]) send(toks[i]);
    n = 0;
    while ((exp_q.size() != 0 || exp_err != 0 || busy) && n < 400) begin
      step();
      n++;
    end
    step();
    chk("drain_chars", 32'(exp_q.size()), 0);
    chk("drain_errs", 32'(exp_err), 0);
    chk("drain_idle", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
